// File: rtl/actbuf_feeder_if.sv
// Upstream word stream and packed-beat stream of the activation-buffer feeder.
// The slave side is the feeder itself; the master side is the loader/array environment.
`ifndef ACTBUF_DATA_LEN
`define ACTBUF_DATA_LEN 16
`endif

interface actbuf_feeder_if #(
    parameter int DATA_W = `ACTBUF_DATA_LEN
);
    logic [DATA_W-1:0]   in_data;
    logic                in_vld;
    logic                in_rdy;
    logic [2*DATA_W-1:0] actbuf_wr_data;
    logic                actbuf_wr_vld;
    logic                actbuf_wr_req;

    modport master (
        output in_data, in_vld, actbuf_wr_req,
        input  in_rdy, actbuf_wr_data, actbuf_wr_vld
    );

    modport slave (
        input  in_data, in_vld, actbuf_wr_req,
        output in_rdy, actbuf_wr_data, actbuf_wr_vld
    );
endinterface

// File: rtl/actbuf_feeder.sv
// Packs pairs of activation words into double-width beats, buffers them in a
// small FIFO and feeds the systolic array's activation-buffer write port.
`ifndef ACTBUF_DATA_LEN
`define ACTBUF_DATA_LEN 16
`endif

module actbuf_feeder #(
    parameter int DATA_W     = `ACTBUF_DATA_LEN,
    parameter int FIFO_DEPTH = 8,
    parameter int LEN_W      = 16
) (
    input  logic                          clk_h,
    input  logic                          rst,
    input  logic                          start,
    input  logic [LEN_W-1:0]              cfg_len,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    actbuf_feeder_if.slave                bus
);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    localparam logic [LEN_W-1:0] BEAT_ONE = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W:0]   WORD_ONE = {{LEN_W{1'b0}}, 1'b1};
    localparam logic [AW:0]      PTR_ONE  = {{AW{1'b0}}, 1'b1};

    logic [1:0]          state_r;
    logic [1:0]          state_nxt_s;
    logic [LEN_W-1:0]    beats_left_r;
    logic [LEN_W:0]      words_left_r;
    logic                half_r;
    logic [DATA_W-1:0]   pack_lo_r;
    logic [2*DATA_W-1:0] mem_r [FIFO_DEPTH];
    logic [AW:0]         wr_ptr_r;
    logic [AW:0]         rd_ptr_r;

    logic fifo_empty_s;
    logic fifo_full_s;
    logic in_rdy_s;
    logic in_fire_s;
    logic push_s;
    logic pop_s;
    logic last_pop_s;

    // Handshake and FIFO status decode from registered state
    always_comb begin
        fifo_empty_s = (wr_ptr_r == rd_ptr_r);
        fifo_full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                       (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        // a second word may only complete a pair when there is room for it
        in_rdy_s     = (state_r == RUN) && (words_left_r != {(LEN_W+1){1'b0}}) &&
                       !(half_r && fifo_full_s);
        in_fire_s    = bus.in_vld && in_rdy_s;
        push_s       = in_fire_s && half_r;
        pop_s        = !fifo_empty_s && bus.actbuf_wr_req;
        last_pop_s   = pop_s && (beats_left_r == BEAT_ONE);
    end

    // Transfer sequencing
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (cfg_len != {LEN_W{1'b0}}) begin
                        state_nxt_s = RUN;
                    end else begin
                        state_nxt_s = FIN;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (last_pop_s) begin
                    state_nxt_s = FIN;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            FIN:     state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Control state, counters, pair packing and FIFO pointers
    always_ff @(posedge clk_h or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            beats_left_r <= {LEN_W{1'b0}};
            words_left_r <= {(LEN_W+1){1'b0}};
            half_r       <= 1'b0;
            pack_lo_r    <= {DATA_W{1'b0}};
            wr_ptr_r     <= {(AW+1){1'b0}};
            rd_ptr_r     <= {(AW+1){1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if ((state_r == IDLE) && start) begin
                beats_left_r <= cfg_len;
                words_left_r <= {cfg_len, 1'b0};
            end else begin
                if (pop_s && (beats_left_r != {LEN_W{1'b0}})) begin
                    beats_left_r <= beats_left_r - BEAT_ONE;
                end
                if (in_fire_s) begin
                    words_left_r <= words_left_r - WORD_ONE;
                end
            end
            if (in_fire_s) begin
                half_r <= !half_r;
                if (!half_r) begin
                    pack_lo_r <= bus.in_data;
                end
            end
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Beat storage; contents are don't-care while empty, so no reset needed
    always_ff @(posedge clk_h) begin
        if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= {bus.in_data, pack_lo_r};
        end
    end

    assign busy               = (state_r == RUN);
    assign done               = (state_r == FIN);
    assign fifo_level         = wr_ptr_r - rd_ptr_r;
    assign bus.in_rdy         = in_rdy_s;
    assign bus.actbuf_wr_vld  = !fifo_empty_s;
    // gated so stale storage never shows on the bus after reset
    assign bus.actbuf_wr_data = fifo_empty_s ? {(2*DATA_W){1'b0}} : mem_r[rd_ptr_r[AW-1:0]];
endmodule

// File: tb/tb_actbuf_feeder.sv
// Directed bench for actbuf_feeder: table of transfer scenarios plus hand-written
// reset and idle sequences, checked against a bench-side word/level model.
module tb_actbuf_feeder;
    localparam int DATA_W = 16;
    localparam int LEN_W  = 16;
    localparam int LVL_W  = 4;

    logic              clk_h = 1'b0;
    logic              rst;
    logic              start;
    logic [LEN_W-1:0]  cfg_len;
    logic              busy;
    logic              done;
    logic [LVL_W-1:0]  fifo_level;

    int nchecks = 0;
    int nerrors = 0;

    actbuf_feeder_if #(.DATA_W(DATA_W)) bif ();

    actbuf_feeder #(.DATA_W(DATA_W), .FIFO_DEPTH(8), .LEN_W(LEN_W)) u_dut (
        .clk_h      (clk_h),
        .rst        (rst),
        .start      (start),
        .cfg_len    (cfg_len),
        .busy       (busy),
        .done       (done),
        .fifo_level (fifo_level),
        .bus        (bif.slave)
    );

    always #5 clk_h = ~clk_h;

    typedef struct {
        int                len;
        int                mode;        // 0 req high, 1 toggle, 2 low until stall, 3 low until stall then toggle
        int                stall;
        int                restart_at;  // cycle of an ignored start pulse, -1 none
        logic [DATA_W-1:0] base;
        int                exp_acc;
        int                exp_beats;
        int                exp_busy;
        int                chk_gaps;
        int                exp_acc_stall; // -1 skip
        int                exp_lev_stall;
    } vec_t;

    vec_t vecs[6];

    int res_acc, res_beats, res_dones, res_done_cyc, res_last_pop, res_gaps;
    int res_max_lev, res_busy, res_acc_stall, res_lev_stall, res_rdy_stall, res_timeout;

    task automatic check(input string name, input longint act, input longint exp);
        nchecks++;
        if (act != exp) begin
            nerrors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_done"},  done, 0);
        check({tag, "_rdy"},   bif.in_rdy, 0);
        check({tag, "_vld"},   bif.actbuf_wr_vld, 0);
        check({tag, "_data"},  bif.actbuf_wr_data, 0);
        check({tag, "_level"}, fifo_level, 0);
    endtask

    function automatic logic req_of(input int mode, input int stall, input int cyc);
        case (mode)
            0:       return 1'b1;
            1:       return (cyc % 2) == 0;
            2:       return cyc >= stall;
            3:       return (cyc >= stall) && ((cyc % 2) == 0);
            default: return 1'b1;
        endcase
    endfunction

    task automatic run_xfer(input vec_t v, input string tag, input int budget);
        int cyc;
        int post;
        int model_lev;
        logic [2*DATA_W-1:0] exp_beat;
        logic [DATA_W-1:0] lo_w;
        logic [DATA_W-1:0] hi_w;
        res_acc = 0; res_beats = 0; res_dones = 0; res_done_cyc = -1; res_last_pop = -1;
        res_gaps = 0; res_max_lev = 0; res_busy = 0; res_acc_stall = -1; res_lev_stall = -1;
        res_rdy_stall = -1; res_timeout = 0;
        model_lev = 0;
        post = -1;
        @(posedge clk_h); #1;
        start = 1'b1;
        cfg_len = LEN_W'(v.len);
        bif.in_vld = 1'b1;
        bif.in_data = v.base;
        bif.actbuf_wr_req = 1'b0;
        @(posedge clk_h); #1;
        cyc = 0;
        while (res_timeout == 0 && post != 0) begin
            start = (cyc == v.restart_at);
            cfg_len = (cyc == v.restart_at) ? LEN_W'(9) : LEN_W'(v.len);
            bif.actbuf_wr_req = req_of(v.mode, v.stall, cyc);
            @(negedge clk_h);
            check({tag, "_level"}, fifo_level, model_lev);
            check({tag, "_vld"}, bif.actbuf_wr_vld, (model_lev != 0));
            if (int'(fifo_level) > res_max_lev) res_max_lev = int'(fifo_level);
            if (cyc == v.stall - 1) begin
                res_acc_stall = res_acc;
                res_lev_stall = int'(fifo_level);
                res_rdy_stall = int'(bif.in_rdy);
            end
            if (busy) res_busy = 1;
            if (bif.actbuf_wr_vld && bif.actbuf_wr_req) begin
                lo_w = v.base + DATA_W'(2 * res_beats);
                hi_w = v.base + DATA_W'(2 * res_beats + 1);
                exp_beat = {hi_w, lo_w};
                check({tag, "_beat"}, bif.actbuf_wr_data, exp_beat);
                if (res_last_pop >= 0 && cyc != res_last_pop + 1) res_gaps += cyc - res_last_pop - 1;
                res_last_pop = cyc;
                res_beats++;
                model_lev--;
            end
            if (bif.in_vld && bif.in_rdy) begin
                res_acc++;
                if (res_acc % 2 == 0) model_lev++;
            end
            if (done) begin
                res_dones++;
                if (res_dones == 1) begin
                    res_done_cyc = cyc;
                    post = 3;
                end
            end
            if (post > 0) post--;
            @(posedge clk_h); #1;
            bif.in_data = v.base + DATA_W'(res_acc);
            cyc++;
            if (cyc >= budget) res_timeout = 1;
        end
        start = 1'b0;
        bif.in_vld = 1'b0;
        bif.actbuf_wr_req = 1'b0;
        check({tag, "_timeout"}, res_timeout, 0);
    endtask

    task automatic apply_vec(input vec_t v, input string tag);
        run_xfer(v, tag, 200);
        check({tag, "_accepted"}, res_acc, v.exp_acc);
        check({tag, "_beats"}, res_beats, v.exp_beats);
        check({tag, "_dones"}, res_dones, 1);
        check({tag, "_busy_seen"}, res_busy, v.exp_busy);
        check({tag, "_max_level_ok"}, (res_max_lev <= 8), 1);
        if (v.len == 0) check({tag, "_done_cyc"}, res_done_cyc, 0);
        else            check({tag, "_done_cyc"}, res_done_cyc, res_last_pop + 1);
        if (v.chk_gaps != 0) check({tag, "_gaps"}, res_gaps, 0);
        if (v.exp_acc_stall >= 0) begin
            check({tag, "_acc_at_stall"}, res_acc_stall, v.exp_acc_stall);
            check({tag, "_level_at_stall"}, res_lev_stall, v.exp_lev_stall);
            check({tag, "_rdy_at_stall"}, res_rdy_stall, 0);
        end
        check({tag, "_idle_busy"}, busy, 0);
        check({tag, "_idle_rdy"}, bif.in_rdy, 0);
    endtask

    initial begin
        int acc;
        vec_t post_rst;
        //                  len mode stall rst  base       acc beats busy gaps accS levS
        vecs[0] = '{4,  0, 0,  -1, 16'h0001, 8,  4,  1, 0, -1, 0};
        vecs[1] = '{12, 2, 30, -1, 16'h0001, 24, 12, 1, 1, 17, 8};
        vecs[2] = '{10, 3, 6,  -1, 16'h0100, 20, 10, 1, 0, -1, 0};
        vecs[3] = '{0,  0, 0,  -1, 16'h0200, 0,  0,  0, 0, -1, 0};
        vecs[4] = '{3,  0, 0,  2,  16'h3000, 6,  3,  1, 0, -1, 0};
        vecs[5] = '{5,  1, 0,  -1, 16'hFFFC, 10, 5,  1, 0, -1, 0};
        post_rst = '{1, 0, 0, -1, 16'hA000, 2, 1, 1, 0, -1, 0};

        rst = 1'b1;
        start = 1'b0;
        cfg_len = '0;
        bif.in_vld = 1'b0;
        bif.in_data = '0;
        bif.actbuf_wr_req = 1'b0;
        #3;
        check_outputs_zero("reset");
        @(posedge clk_h); @(posedge clk_h); #1;
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            apply_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // reset in the middle of a len=6 transfer with words stuck in the FIFO
        @(posedge clk_h); #1;
        start = 1'b1;
        cfg_len = LEN_W'(6);
        bif.in_vld = 1'b1;
        bif.in_data = 16'h5000;
        bif.actbuf_wr_req = 1'b0;
        @(posedge clk_h); #1;
        start = 1'b0;
        acc = 0;
        for (int c = 0; c < 50 && acc < 5; c++) begin
            @(negedge clk_h);
            if (bif.in_vld && bif.in_rdy) acc++;
            @(posedge clk_h); #1;
            bif.in_data = 16'h5000 + DATA_W'(acc);
        end
        check("midrst_accepted", acc, 5);
        check("midrst_level_before", fifo_level, 2);
        check("midrst_busy_before", busy, 1);
        rst = 1'b1;
        #1;
        check_outputs_zero("midrst");
        bif.in_vld = 1'b0;
        @(posedge clk_h); #1;
        rst = 1'b0;
        apply_vec(post_rst, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end
endmodule
